load_controller: RTL and testbench
==================================

// Module: load_controller
// PURPOSE
//   Control FSM for the load datapath. Accepts a header word and then message words over a
//   valid/ready stream, and drives the datapath strobes: control regs, padding, buffer
//   counter and SIPO load. Hands each filled rate block to the permutation stage over a
//   valid/ready handshake, and flags the final (padded) block.
// PARAMETERS
//   BLK_CNT_W   16   width of the optional absorbed-block statistics counter
// PORTS
//   clk                          in   1            system clock; single clock domain
//   rst                          in   1            synchronous, active-high reset
//   valid_in                     in   1            upstream word valid (header or data)
//   ready_in                     out  1            controller accepts the word this cycle
//   first_incomplete_input_word  in   1            datapath: current word is partially valid
//   input_size_reached           in   1            datapath: all message words consumed
//   input_buffer_full            in   1            datapath: SIPO holds a full rate block
//   last_input_block             in   1            datapath: padding closed in this block
//   load_enable                  out  1            shift the SIPO / step the size counter
//   control_regs_enable          out  1            latch mode, output size, input size
//   padding_enable               out  1            padding generator active on this word
//   padding_reset                out  1            clear padding generator state
//   input_counter_en             out  1            increment the buffer fill counter
//   input_counter_load           out  1            reload/clear the buffer fill counter
//   block_valid                  out  1            full block presented to the permutation stage
//   block_ready                  in   1            permutation stage accepts the block
//   block_last                   out  1            qualifies block_valid: final block of message
//   busy                         out  1            message in progress (state != IDLE)
// BEHAVIOUR
//   - Reset: state=IDLE. All outputs 0, except ready_in=1 in IDLE.
//   - States: IDLE, LOAD, PAD, BLOCK. The state encoding is a package enum.
//   - IDLE: ready_in=1. On valid_in, assert control_regs_enable, padding_reset and
//     input_counter_load for that cycle, then go to LOAD.
//   - LOAD:
//     - ready_in = ~input_buffer_full & ~input_size_reached.
//     - On a handshake: load_enable=1 and input_counter_en=1.
//     - padding_enable=1 on that same word if first_incomplete_input_word.
//   - LOAD exits (evaluated on registered datapath flags):
//     - input_buffer_full -> BLOCK.
//     - else input_size_reached -> PAD.
//     - A zero-length message reaches PAD one cycle after the header.
//   - PAD: ready_in=0. Every cycle, padding_enable=load_enable=input_counter_en=1 and upstream
//     data is ignored. Leave for BLOCK when input_buffer_full is sampled. No load is issued
//     in that cycle.
//   - BLOCK: block_valid=1, block_last=last_input_block. No datapath strobes. Hold until
//     block_ready. On the handshake, input_counter_load=1 and:
//     - block_last=1 -> IDLE.
//     - else input_size_reached -> PAD.
//     - else -> LOAD.
//   - block_valid/block_last are stable while waiting. block_ready outside BLOCK is ignored.
//   - Message that exactly fills a block: BLOCK (block_last=0), then one full PAD block
//     with block_last=1.
//   - Latency: a block is offered the cycle after input_buffer_full rises. Restart to
//     LOAD/PAD costs 1 cycle.
//   - rst mid-message: return to IDLE next edge, block_valid drops, no partial handshake.
//   - Strobes are Moore/Mealy combinational from state plus handshake inputs. No
//     combinational path from block_ready to ready_in.
// CONFIGURATION
//   - LOAD_CTRL_STATS_EN defined: extra output port blocks_absorbed [BLK_CNT_W-1:0].
//     - Increments on every block handshake; wraps at max.
//     - Cleared by rst and by a header accept in IDLE.
//   - Undefined: the port and counter are absent; behaviour otherwise identical.
// STRUCTURE
//   - keccak_pkg holds typedef enum logic[1:0] load_ctrl_state_t {LC_IDLE, LC_LOAD, LC_PAD,
//     LC_BLOCK}. Mode vectors and rate word counts (17/21) stay in the package.
//   - Single module. No sub-module: next-state and output decode in one always_comb, state
//     register in one always_ff.
// TESTING
//   1. Header, then 21 words for SHAKE128 (1344 bits, no stalls): 21 load_enable ->
//      BLOCK(last=0); after block_ready, 21 PAD loads -> BLOCK(last=1) -> IDLE.
//   2. SHAKE256 with a 100-bit message (2 words, 2nd incomplete): padding_enable on word 2,
//      15 PAD cycles, then block_valid=1 with block_last=1.
//   3. Zero-length message: header only -> PAD for 21 cycles, ready_in=0 throughout ->
//      one block with block_last=1.
//   4. Hold block_ready=0 for 10 cycles in BLOCK: block_valid/block_last stable, ready_in=0,
//      no load_enable. Release -> input_counter_load pulse, next state correct.
//   5. rst asserted in LOAD after 5 words: next cycle IDLE, ready_in=1, all strobes 0. A new
//      header is accepted normally.
//   6. LOAD_CTRL_STATS_EN: 3-block message -> blocks_absorbed=3; new header -> 0.

Source files
------------

// File: rtl/keccak_pkg.sv
// keccak_pkg: load controller state encoding, mode vectors and rate block sizes in words.
package keccak_pkg;

    typedef enum logic [1:0] {LC_IDLE, LC_LOAD, LC_PAD, LC_BLOCK} load_ctrl_state_t;

    localparam logic [1:0] MODE_SHAKE128 = 2'd0;
    localparam logic [1:0] MODE_SHAKE256 = 2'd1;

    localparam int RATE_WORDS_SHAKE128 = 21;
    localparam int RATE_WORDS_SHAKE256 = 17;

    function automatic int rate_words(input logic [1:0] mode);
        return (mode == MODE_SHAKE256) ? RATE_WORDS_SHAKE256 : RATE_WORDS_SHAKE128;
    endfunction

endpackage

// File: rtl/load_controller.sv
// load_controller: header/data intake FSM driving load datapath strobes and block handoff.
// Define LOAD_CTRL_STATS_EN to add the blocks_absorbed statistics counter port.
module load_controller
    import keccak_pkg::*;
#(
    parameter int BLK_CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    output logic ready_in,
    input  logic first_incomplete_input_word,
    input  logic input_size_reached,
    input  logic input_buffer_full,
    input  logic last_input_block,
    output logic load_enable,
    output logic control_regs_enable,
    output logic padding_enable,
    output logic padding_reset,
    output logic input_counter_en,
    output logic input_counter_load,
    output logic block_valid,
    input  logic block_ready,
    output logic block_last,
    output logic busy
`ifdef LOAD_CTRL_STATS_EN
    ,
    output logic [BLK_CNT_W-1:0] blocks_absorbed
`endif
);

    load_ctrl_state_t state, next_state;
    logic data_hs;

    always_ff @(posedge clk)
        if (rst) state <= LC_IDLE;
        else     state <= next_state;

    assign data_hs = valid_in & ~input_buffer_full & ~input_size_reached;

    always_comb begin
        next_state          = state;
        ready_in            = 1'b0;
        load_enable         = 1'b0;
        control_regs_enable = 1'b0;
        padding_enable      = 1'b0;
        padding_reset       = 1'b0;
        input_counter_en    = 1'b0;
        input_counter_load  = 1'b0;
        block_valid         = 1'b0;
        block_last          = 1'b0;
        busy                = state != LC_IDLE;
        case (state)
            LC_IDLE: begin
                ready_in            = 1'b1;
                control_regs_enable = valid_in;
                padding_reset       = valid_in;
                input_counter_load  = valid_in;
                next_state          = valid_in ? LC_LOAD : LC_IDLE;
            end
            LC_LOAD: begin
                ready_in         = ~input_buffer_full & ~input_size_reached;
                load_enable      = data_hs;
                input_counter_en = data_hs;
                padding_enable   = data_hs & first_incomplete_input_word;
                next_state       = input_buffer_full ? LC_BLOCK : input_size_reached ? LC_PAD : LC_LOAD;
            end
            // Padding words fill the remainder of the block; the full cycle issues no load.
            LC_PAD: begin
                padding_enable   = ~input_buffer_full;
                load_enable      = ~input_buffer_full;
                input_counter_en = ~input_buffer_full;
                next_state       = input_buffer_full ? LC_BLOCK : LC_PAD;
            end
            default: begin
                block_valid        = 1'b1;
                block_last         = last_input_block;
                input_counter_load = block_ready;
                if (block_ready)
                    next_state = last_input_block ? LC_IDLE : input_size_reached ? LC_PAD : LC_LOAD;
            end
        endcase
    end

`ifdef LOAD_CTRL_STATS_EN
    always_ff @(posedge clk)
        if (rst || (state == LC_IDLE && valid_in)) blocks_absorbed <= '0;
        else if (block_valid && block_ready)     blocks_absorbed <= blocks_absorbed + 1'b1;
`endif

endmodule

// File: tb/tb_load_controller.sv
// tb_load_controller: scoreboard bench with a behavioural datapath model feeding the flags.
module tb_load_controller;
    import keccak_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_in, ready_in, first_incomplete_input_word, input_size_reached;
    logic input_buffer_full, last_input_block, load_enable, control_regs_enable;
    logic padding_enable, padding_reset, input_counter_en, input_counter_load;
    logic block_valid, block_last, busy;
    logic block_ready = 1'b1;
`ifdef LOAD_CTRL_STATS_EN
    logic [15:0] blocks_absorbed;
`endif

    int vectors = 0;
    int miscompares = 0;

    int msg_n = 0, rate = RATE_WORDS_SHAKE128;
    int consumed = 0, fill = 0, loads_cnt = 0, pad_cnt = 0, pe_data = 0, rdy_busy = 0;
    bit partial = 1'b0, pad_done = 1'b0, send_hdr = 1'b0, data_on = 1'b0;
    bit exp_q[$];

    always #5 clk = ~clk;

    load_controller #(.BLK_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
        .first_incomplete_input_word(first_incomplete_input_word),
        .input_size_reached(input_size_reached), .input_buffer_full(input_buffer_full),
        .last_input_block(last_input_block), .load_enable(load_enable),
        .control_regs_enable(control_regs_enable), .padding_enable(padding_enable),
        .padding_reset(padding_reset), .input_counter_en(input_counter_en),
        .input_counter_load(input_counter_load), .block_valid(block_valid),
        .block_ready(block_ready), .block_last(block_last), .busy(busy)
`ifdef LOAD_CTRL_STATS_EN
        , .blocks_absorbed(blocks_absorbed)
`endif
    );

    // Datapath model: word count, buffer fill and padding-closed flags, all registered.
    assign valid_in = send_hdr | (data_on && consumed < msg_n);
    assign first_incomplete_input_word = partial && msg_n > 0 && consumed == msg_n - 1;
    assign input_size_reached = consumed == msg_n;
    assign input_buffer_full = fill == rate;
    assign last_input_block = pad_done;

    always @(posedge clk) begin
        if (rst || control_regs_enable) begin
            consumed <= 0; pad_cnt <= 0; pe_data <= 0; rdy_busy <= 0;
        end else begin
            if (busy && valid_in && ready_in) consumed <= consumed + 1;
            if (padding_enable && !(busy && valid_in && ready_in)) pad_cnt <= pad_cnt + 1;
            if (padding_enable && busy && valid_in && ready_in) pe_data <= pe_data + 1;
            if (busy && ready_in) rdy_busy <= rdy_busy + 1;
        end
        fill      <= (rst || input_counter_load) ? 0 : fill + int'(input_counter_en);
        pad_done  <= (rst || input_counter_load) ? 1'b0 : (pad_done | padding_enable);
        loads_cnt <= (rst || input_counter_load) ? 0 : loads_cnt + int'(load_enable);
    end

    task automatic start_msg(input int words, input bit part, input int r);
        int nb, rem;
        msg_n = words; partial = part; rate = r;
        nb = words / r; rem = words % r;
        if (part && rem == 0 && words > 0) begin
            for (int i = 0; i < nb; i++) exp_q.push_back(i == nb - 1);
        end else begin
            for (int i = 0; i < nb; i++) exp_q.push_back(1'b0);
            exp_q.push_back(1'b1);
        end
        @(negedge clk); send_hdr = 1'b1; data_on = 1'b1;
        @(negedge clk); send_hdr = 1'b0;
    endtask

    task automatic drain();
        bit exp;
        int t;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            t = 0;
            while (!(block_valid && block_ready) && t < 400) begin @(negedge clk); t++; end
            vectors++;
            if (t >= 400) begin
                miscompares++;
                $display("FAIL block_timeout: block_valid=%0b after %0d cycles, required 1", block_valid, t);
                exp_q.delete();
            end else begin
                if (block_last !== exp) begin
                    miscompares++;
                    $display("FAIL block_last: got %0b required %0b", block_last, exp);
                end
                vectors++;
                if (loads_cnt != rate) begin
                    miscompares++;
                    $display("FAIL block_loads: got %0d required %0d", loads_cnt, rate);
                end
                @(negedge clk);
            end
        end
        t = 0;
        while (busy && t < 50) begin @(negedge clk); t++; end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL return_idle: busy=%0b required 0", busy);
        end
        data_on = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({ready_in, busy, load_enable, padding_enable, input_counter_en, input_counter_load,
             block_valid, block_last} !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b required 10000000", {ready_in, busy, load_enable,
                     padding_enable, input_counter_en, input_counter_load, block_valid, block_last});
        end
        rst = 1'b0;
    endtask

    task automatic test_exact_fill();
        start_msg(RATE_WORDS_SHAKE128, 1'b0, RATE_WORDS_SHAKE128);
        drain();
        vectors++;
        if (pad_cnt != 21) begin
            miscompares++;
            $display("FAIL exact_fill_pad_cycles: got %0d required 21", pad_cnt);
        end
    endtask

    task automatic test_partial_word();
        start_msg(2, 1'b1, RATE_WORDS_SHAKE256);
        drain();
        vectors++;
        if (pe_data != 1) begin
            miscompares++;
            $display("FAIL partial_pad_on_word: got %0d required 1", pe_data);
        end
        vectors++;
        if (pad_cnt != 15) begin
            miscompares++;
            $display("FAIL partial_pad_cycles: got %0d required 15", pad_cnt);
        end
    endtask

    task automatic test_zero_length();
        start_msg(0, 1'b0, RATE_WORDS_SHAKE128);
        drain();
        vectors++;
        if (pad_cnt != 21 || rdy_busy != 0) begin
            miscompares++;
            $display("FAIL zero_length: pad_cycles=%0d ready_cycles=%0d required 21 and 0", pad_cnt, rdy_busy);
        end
    endtask

    task automatic test_block_hold();
        bit held, exp;
        int t = 0;
        block_ready = 1'b0;
        start_msg(RATE_WORDS_SHAKE128, 1'b0, RATE_WORDS_SHAKE128);
        while (!block_valid && t < 200) begin @(negedge clk); t++; end
        held = block_last;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({block_valid, block_last, ready_in, load_enable} !== {1'b1, held, 2'b00}) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: valid/last/ready/load got %b required %b", i,
                         {block_valid, block_last, ready_in, load_enable}, {1'b1, held, 2'b00});
            end
        end
        block_ready = 1'b1;
        #1;
        exp = exp_q.pop_front();
        vectors++;
        if ({input_counter_load, block_last} !== {1'b1, exp}) begin
            miscompares++;
            $display("FAIL hold_release: counter_load/last got %b required %b", {input_counter_load, block_last}, {1'b1, exp});
        end
        @(negedge clk);
        vectors++;
        if ({busy, block_valid, load_enable, padding_enable} !== 4'b1011) begin
            miscompares++;
            $display("FAIL hold_next_state: busy/valid/load/pad got %b required 1011",
                     {busy, block_valid, load_enable, padding_enable});
        end
        drain();
    endtask

    task automatic test_reset_mid_message();
        int t = 0;
        start_msg(10, 1'b0, RATE_WORDS_SHAKE128);
        while (consumed != 5 && t < 100) begin @(negedge clk); t++; end
        data_on = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, ready_in, load_enable, control_regs_enable, padding_enable, padding_reset,
             input_counter_en, input_counter_load, block_valid, block_last} !== 10'b01_0000_0000) begin
            miscompares++;
            $display("FAIL reset_mid_message: got %b required 0100000000", {busy, ready_in, load_enable,
                     control_regs_enable, padding_enable, padding_reset, input_counter_en,
                     input_counter_load, block_valid, block_last});
        end
        rst = 1'b0;
        exp_q.delete();
        start_msg(3, 1'b0, RATE_WORDS_SHAKE128);
        drain();
    endtask

`ifdef LOAD_CTRL_STATS_EN
    task automatic test_stats();
        start_msg(50, 1'b0, RATE_WORDS_SHAKE128);
        drain();
        vectors++;
        if (blocks_absorbed !== 16'd3) begin
            miscompares++;
            $display("FAIL stats_count: got %0d required 3", blocks_absorbed);
        end
        start_msg(0, 1'b0, RATE_WORDS_SHAKE128);
        vectors++;
        if (blocks_absorbed !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_clear: got %0d required 0", blocks_absorbed);
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_exact_fill();
        test_partial_word();
        test_zero_length();
        test_block_hold();
        test_reset_mid_message();
`ifdef LOAD_CTRL_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
